// File: rtl/text_console_ctrl.sv
// Cursor and character-RAM write controller for the text console: turns received
// bytes into RAM writes, handling printables, newline, backspace, row blanking and clear.
module text_console_ctrl #(
    parameter int         COLS      = 32,
    parameter int         ROWS      = 4,
    parameter int         START_ROW = 1,
    parameter logic [7:0] NL_CODE   = 8'h7E,
    parameter logic [7:0] BS_CODE   = 8'h08,
    parameter logic [7:0] BLANK     = 8'h20,
    parameter int         ROW_CLEAR = 1,
    parameter int         COL_W     = $clog2(COLS),
    parameter int         ROW_W     = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             clear,
    output logic             ram_we,
    output logic [ROW_W-1:0] ram_row,
    output logic [COL_W-1:0] ram_col,
    output logic [7:0]       ram_wdata,
    output logic [ROW_W-1:0] cursor_row,
    output logic [COL_W-1:0] cursor_col,
    output logic             busy,
    output logic             dropped
);

    typedef enum logic [1:0] {IDLE, SWEEP_ROW, SWEEP_ALL} state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] HOME_ROW = ROW_W'(START_ROW);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    state_t           state;
    logic [ROW_W-1:0] sweep_row;
    logic [COL_W-1:0] sweep_col;
    logic             sweep_done;

    logic             is_nl;
    logic             is_bs;
    logic [ROW_W-1:0] next_row;

    // Control codes match on the 7-bit ASCII part only, so bit 7 is ignored.
    assign is_nl    = (rx_data[6:0] == NL_CODE[6:0]);
    assign is_bs    = (rx_data[6:0] == BS_CODE[6:0]);
    assign next_row = (cursor_row == LAST_ROW) ? '0 : cursor_row + ROW_ONE;

    // NOTE: every state and output is assigned with <= in this one clocked block, so
    // all outputs are plain registers and no read sees a same-cycle update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cursor_row <= HOME_ROW;
            cursor_col <= '0;
            ram_we     <= 1'b0;
            ram_row    <= '0;
            ram_col    <= '0;
            ram_wdata  <= '0;
            busy       <= 1'b0;
            dropped    <= 1'b0;
            sweep_row  <= '0;
            sweep_col  <= '0;
            sweep_done <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            if (clear) begin
                // The first cell is written immediately; the sweep registers point at the next one.
                state      <= SWEEP_ALL;
                busy       <= 1'b1;
                dropped    <= 1'b0;
                ram_we     <= 1'b1;
                ram_row    <= '0;
                ram_col    <= '0;
                ram_wdata  <= BLANK;
                sweep_row  <= '0;
                sweep_col  <= COL_ONE;
                sweep_done <= 1'b0;
            end else begin
                if (rx_valid && state != IDLE)
                    dropped <= 1'b1;

                case (state)
                    IDLE: begin
                        if (rx_valid) begin
                            if (is_nl) begin
                                cursor_row <= next_row;
                                cursor_col <= '0;
                                if (ROW_CLEAR != 0) begin
                                    state      <= SWEEP_ROW;
                                    busy       <= 1'b1;
                                    ram_we     <= 1'b1;
                                    ram_row    <= next_row;
                                    ram_col    <= '0;
                                    ram_wdata  <= BLANK;
                                    sweep_row  <= next_row;
                                    sweep_col  <= COL_ONE;
                                    sweep_done <= 1'b0;
                                end
                            end else if (is_bs) begin
                                if (cursor_col != '0) begin
                                    cursor_col <= cursor_col - COL_ONE;
                                    ram_we     <= 1'b1;
                                    ram_row    <= cursor_row;
                                    ram_col    <= cursor_col - COL_ONE;
                                    ram_wdata  <= BLANK;
                                end
                            end else begin
                                ram_we    <= 1'b1;
                                ram_row   <= cursor_row;
                                ram_col   <= cursor_col;
                                ram_wdata <= rx_data;
                                if (cursor_col == LAST_COL) begin
                                    cursor_col <= '0;
                                    cursor_row <= next_row;
                                    // The character occupies this write slot, so the sweep starts at column 0 next cycle.
                                    if (ROW_CLEAR != 0) begin
                                        state      <= SWEEP_ROW;
                                        busy       <= 1'b1;
                                        sweep_row  <= next_row;
                                        sweep_col  <= '0;
                                        sweep_done <= 1'b0;
                                    end
                                end else begin
                                    cursor_col <= cursor_col + COL_ONE;
                                end
                            end
                        end
                    end

                    SWEEP_ROW: begin
                        if (sweep_done) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            ram_we    <= 1'b1;
                            ram_row   <= sweep_row;
                            ram_col   <= sweep_col;
                            ram_wdata <= BLANK;
                            if (sweep_col == LAST_COL)
                                sweep_done <= 1'b1;
                            else
                                sweep_col <= sweep_col + COL_ONE;
                        end
                    end

                    SWEEP_ALL: begin
                        if (sweep_done) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            cursor_row <= HOME_ROW;
                            cursor_col <= '0;
                        end else begin
                            ram_we    <= 1'b1;
                            ram_row   <= sweep_row;
                            ram_col   <= sweep_col;
                            ram_wdata <= BLANK;
                            if (sweep_col == LAST_COL) begin
                                sweep_col <= '0;
                                if (sweep_row == LAST_ROW)
                                    sweep_done <= 1'b1;
                                else
                                    sweep_row <= sweep_row + ROW_ONE;
                            end else begin
                                sweep_col <= sweep_col + COL_ONE;
                            end
                        end
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Scoreboard bench for text_console_ctrl: a cursor-level model queues expected RAM
// writes, a negedge monitor pops and compares them, and the stimulus checks cursor/busy timing.
`timescale 1ns/1ps
module tb_text_console_ctrl;

    localparam int COLS      = 32;
    localparam int ROWS      = 4;
    localparam int START_ROW = 1;
    localparam int ROW_CLEAR = 1;
    localparam int COL_W     = $clog2(COLS);
    localparam int ROW_W     = $clog2(ROWS);
    localparam logic [7:0] NL    = 8'h7E;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] BLANK = 8'h20;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             clear;
    logic             ram_we;
    logic [ROW_W-1:0] ram_row;
    logic [COL_W-1:0] ram_col;
    logic [7:0]       ram_wdata;
    logic [ROW_W-1:0] cursor_row;
    logic [COL_W-1:0] cursor_col;
    logic             busy;
    logic             dropped;

    text_console_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .START_ROW(START_ROW), .NL_CODE(NL), .BS_CODE(BS),
        .BLANK(BLANK), .ROW_CLEAR(ROW_CLEAR), .COL_W(COL_W), .ROW_W(ROW_W)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .clear(clear),
        .ram_we(ram_we), .ram_row(ram_row), .ram_col(ram_col), .ram_wdata(ram_wdata),
        .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy), .dropped(dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int col;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Model state: where the cursor should be and whether a byte has been lost.
    int  m_row;
    int  m_col;
    bit  m_dropped;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input int r, input int c, input int d);
        wr_t w;
        w.row = r;
        w.col = c;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic push_row_blank(input int r);
        for (int c = 0; c < COLS; c++) push_wr(r, c, BLANK);
    endtask

    // Applies one accepted byte to the model; returns whether a character-slot write
    // happens at N+1 and how many cycles busy stays high.
    task automatic model_rx(input logic [7:0] b, output bit wrote, output int busy_len);
        logic [6:0] code;
        code = b[6:0];
        wrote = 0;
        busy_len = 0;
        if (code == NL[6:0]) begin
            m_row = (m_row + 1) % ROWS;
            m_col = 0;
            if (ROW_CLEAR != 0) begin
                push_row_blank(m_row);
                busy_len = COLS;
                wrote = 1;
            end
        end else if (code == BS[6:0]) begin
            if (m_col > 0) begin
                m_col = m_col - 1;
                push_wr(m_row, m_col, BLANK);
                wrote = 1;
            end
        end else begin
            push_wr(m_row, m_col, b);
            wrote = 1;
            if (m_col == COLS - 1) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
                if (ROW_CLEAR != 0) begin
                    push_row_blank(m_row);
                    busy_len = COLS + 1;
                end
            end else begin
                m_col = m_col + 1;
            end
        end
    endtask

    // Called at N+1 (+1ns). Every busy cycle of a sweep must also carry a write;
    // an optional byte is injected at sweep cycle 'inject' and must be dropped.
    task automatic run_busy(input int len, input int inject);
        bit ok;
        ok = 1;
        for (int k = 0; k < len; k++) begin
            if (!(busy === 1'b1 && ram_we === 1'b1)) ok = 0;
            if (k == inject) begin
                rx_data  = 8'h55;
                rx_valid = 1'b1;
                m_dropped = 1;
            end
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
        check("sweep_busy_and_we", {31'd0, ok}, 32'd1);
        check("busy_falls", busy, 0);
        check("we_after_sweep", ram_we, 0);
    endtask

    task automatic do_rx(input logic [7:0] b);
        bit wrote;
        int busy_len;
        model_rx(b, wrote, busy_len);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check("we_latency", ram_we, {31'd0, wrote});
        check("cursor_row", cursor_row, m_row);
        check("cursor_col", cursor_col, m_col);
        check("dropped", dropped, {31'd0, m_dropped});
        if (busy_len > 0)
            run_busy(busy_len, -1);
        else
            check("busy_idle", busy, 0);
    endtask

    task automatic do_clear(input int inject, input bit with_rx);
        @(posedge clk);
        #1;
        clear = 1'b1;
        if (with_rx) begin
            rx_data  = 8'h41;
            rx_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        clear    = 1'b0;
        rx_valid = 1'b0;
        exp_q.delete();
        for (int r = 0; r < ROWS; r++) push_row_blank(r);
        m_dropped = 0;
        check("clear_drops_reset", dropped, 0);
        run_busy(ROWS * COLS, inject);
        m_row = START_ROW;
        m_col = 0;
        check("clear_cursor_row", cursor_row, m_row);
        check("clear_cursor_col", cursor_col, m_col);
        check("clear_dropped", dropped, {31'd0, m_dropped});
    endtask

    task automatic check_reset_values();
        check("rst_we", ram_we, 0);
        check("rst_row", ram_row, 0);
        check("rst_col", ram_col, 0);
        check("rst_wdata", ram_wdata, 0);
        check("rst_cursor_row", cursor_row, START_ROW);
        check("rst_cursor_col", cursor_col, 0);
        check("rst_busy", busy, 0);
        check("rst_dropped", dropped, 0);
    endtask

    function automatic logic [7:0] rand_printable();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while (b[6:0] == NL[6:0] || b[6:0] == BS[6:0]);
        return b;
    endfunction

    // Monitor: every write the DUT presents must be the next one the model predicted.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got row %0d col %0d data %0h expected no write at %0t",
                         ram_row, ram_col, ram_wdata, $time);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_row", ram_row, w.row);
                check("wr_col", ram_col, w.col);
                check("wr_data", ram_wdata, w.data);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        clear    = 1'b0;
        m_row = START_ROW;
        m_col = 0;
        m_dropped = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        reset = 1'b0;

        // 'A' lands at (1,0) one cycle later.
        do_rx(8'h41);
        check("a_row", ram_row, 1);
        check("a_col", ram_col, 0);
        check("a_wdata", ram_wdata, 8'h41);
        do_rx(BS);

        // A full row of printables wraps into row 2, which is then blanked.
        for (int i = 0; i < COLS; i++) do_rx(rand_printable());

        // Reach (3,5), then newline wraps to row 0.
        do_rx(NL);
        for (int i = 0; i < 5; i++) do_rx(rand_printable());
        do_rx(NL);

        // Backspace inside a row and at column 0.
        do_rx(NL);
        for (int i = 0; i < 3; i++) do_rx(rand_printable());
        do_rx(BS);
        do_rx(BS);
        do_rx(BS);
        do_rx(BS);
        do_rx(8'h88);

        // Clear with a byte arriving mid-sweep, then clear coincident with a byte.
        do_clear(40, 1'b0);
        do_clear(-1, 1'b1);

        // Reset in the middle of a row sweep.
        do_rx(rand_printable());
        begin
            bit wrote;
            int busy_len;
            model_rx(NL, wrote, busy_len);
            @(posedge clk);
            #1;
            rx_data  = NL;
            rx_valid = 1'b1;
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            check("mid_sweep_busy", busy, 1);
            reset = 1'b1;
            @(posedge clk);
            #1;
            exp_q.delete();
            m_row = START_ROW;
            m_col = 0;
            m_dropped = 0;
            check_reset_values();
            reset = 1'b0;
        end

        // Randomized mix, including high-bit aliases of the control codes.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3)
                do_clear(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, ROWS * COLS - 1)) : -1,
                         1'($urandom_range(0, 1)));
            else if (r < 13)
                do_rx(($urandom_range(0, 1) == 1) ? 8'hFE : NL);
            else if (r < 25)
                do_rx(($urandom_range(0, 1) == 1) ? 8'h88 : BS);
            else
                do_rx(rand_printable());
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_console_ctrl.md
Name: text_console_ctrl

Overview:
- Cursor and character-RAM write controller for the VGA text console.
- Consumes received UART bytes and turns each one into writes to the dual-port character RAM, through the RAM's write port.
- Handles printable characters, newline, backspace, full-screen clear, and optional clearing of each row as the cursor enters it.
- Generalises the fixed single-screen cursor logic to any COLS x ROWS geometry and to configurable control codes.

Parameters:
- COLS, 32: characters per row; any value >= 2, power of two not required.
- ROWS, 4: rows on screen; any value >= 2.
- START_ROW, 1: cursor row after reset and after clear.
- NL_CODE, 8'h7E: byte treated as newline (compared on bits [6:0]).
- BS_CODE, 8'h08: byte treated as backspace (compared on bits [6:0]).
- BLANK, 8'h20: fill character written by clear and backspace.
- ROW_CLEAR, 1: 1 = blank a row whenever the cursor advances into it; 0 = leave old contents.
- COL_W, $clog2(COLS): column address width.
- ROW_W, $clog2(ROWS): row address width.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid in the same cycle
- clear  in  1  one-cycle strobe; blank the whole screen and home the cursor
- ram_we  out  1  character-RAM write enable
- ram_row  out  ROW_W  write row address
- ram_col  out  COL_W  write column address
- ram_wdata  out  8  write data
- cursor_row  out  ROW_W  current cursor row
- cursor_col  out  COL_W  current cursor column
- busy  out  1  high while a sweep is in progress; new bytes are not accepted
- dropped  out  1  sticky: a byte arrived while busy

Behaviour:
- All outputs are registered.
- Reset:
  - State IDLE; cursor = (START_ROW, 0).
  - ram_we = 0, ram_row = 0, ram_col = 0, ram_wdata = 0.
  - busy = 0, dropped = 0.
  - RAM contents are untouched.
- States: IDLE, SWEEP_ROW, SWEEP_ALL.
- IDLE, rx_valid with a printable byte (neither NL_CODE nor BS_CODE):
  - Cycle N+1: ram_we = 1, address = cursor at cycle N, ram_wdata = rx_data.
  - The cursor update is visible at N+1.
  - Advance rule: col < COLS-1 gives col+1. col == COLS-1 gives col = 0 and row+1; row ROWS-1 wraps to 0.
- IDLE, rx_valid with NL_CODE:
  - No character write.
  - Cursor becomes (row+1 mod ROWS, 0) at N+1.
- IDLE, rx_valid with BS_CODE:
  - col > 0: col-1, and BLANK is written at the new position at N+1.
  - col == 0: no write, cursor unchanged; backspace never moves to the previous row.
- Row change with ROW_CLEAR = 1 (newline or wrap):
  - Enter SWEEP_ROW; busy = 1 from N+1.
  - Writes BLANK to (new_row, 0..COLS-1), one column per cycle, during cycles N+1..N+COLS.
  - When the row change is caused by a printable character wrapping, its own write occurs at N+1 and the sweep starts at N+2 instead.
  - busy falls the cycle after the last sweep write.
  - The cursor is already at (new_row, 0) throughout the sweep.
- Row change with ROW_CLEAR = 0: no sweep, busy stays 0.
- clear in any state:
  - Enter SWEEP_ALL at N+1, aborting any SWEEP_ROW in progress.
  - Writes BLANK to every cell in row-major order from (0,0) to (ROWS-1, COLS-1): ROWS*COLS write cycles, busy = 1.
  - dropped clears at N+1.
  - When the sweep completes, cursor = (START_ROW, 0) and the state returns to IDLE.
- clear during SWEEP_ALL restarts the sweep from (0,0).
- Simultaneous events:
  - clear and rx_valid in the same cycle: clear wins and the byte is dropped; dropped is not set.
  - rx_valid while busy (not coincident with clear): byte discarded, dropped = 1 until the next clear or reset.
- ram_we is never high in two consecutive cycles from IDLE-originated single writes, except during sweeps.
- Reset asserted mid-sweep: the sweep stops immediately; the next cycle shows the reset values.

Test Plan (COLS=32, ROWS=4, START_ROW=1, ROW_CLEAR=1):
- Reset, then rx 'A' (0x41) -> one cycle later ram_we = 1, row 1, col 0, wdata 0x41; cursor (1,1).
- 32 printable bytes from (1,0) -> the last byte is written at (1,31); cursor (2,0); busy for 32 cycles writing 0x20 to (2,0..31).
- Cursor (3,5), rx 0x7E -> cursor (0,0); row 0 blanked over 32 cycles; no write of 0x7E.
- Cursor (1,3), rx 0x08 -> write 0x20 at (1,2), cursor (1,2). At (1,0), rx 0x08 -> no write, cursor unchanged.
- clear pulse -> 128 consecutive writes of 0x20 from (0,0) to (3,31); a byte sent mid-sweep sets dropped = 1; afterwards cursor (1,0), busy = 0.
- clear coincident with rx_valid, and reset asserted mid-SWEEP_ROW -> byte ignored and dropped stays 0; after reset, ram_we = 0 and cursor (1,0) the next cycle.
